// File: rtl/cpu_fifo_pkg.sv
// Shared register map, bit positions and reset helpers for the CPU-mapped FIFO.
package cpu_fifo_pkg;

  localparam logic [3:0] ADDR_DATA   = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h1;
  localparam logic [3:0] ADDR_COUNT  = 4'h2;
  localparam logic [3:0] ADDR_CTRL   = 4'h3;
  localparam logic [3:0] ADDR_THRESH = 4'h4;

  localparam int STAT_EMPTY     = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVERFLOW  = 2;
  localparam int STAT_UNDERFLOW = 3;
  localparam int STAT_LEVEL     = 4;
  localparam int STAT_W         = 5;

  localparam int CTRL_FLUSH      = 0;
  localparam int CTRL_CLR_STICKY = 1;
  localparam int CTRL_IRQ_EN     = 7;

  localparam int THRESH_W = 5;

  // Threshold comes out of reset at half the FIFO depth.
  function automatic logic [THRESH_W-1:0] threshRstVal(input int depth);
    return THRESH_W'(depth / 2);
  endfunction

endpackage

// File: rtl/fifo_core.sv
// FIFO storage with wrapping pointers and an occupancy counter; push/pop strobes
// are self-guarding against full/empty, flush clears pointers and count.
module fifo_core #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wrData,
  output logic [WIDTH-1:0]         rdData,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic             doPush;
  logic             doPop;

  assign full   = (count == FULL_CNT);
  assign empty  = (count == '0);
  assign doPush = push & ~full;
  assign doPop  = pop & ~empty;
  assign rdData = mem[rdPtr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rstN || flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_ONE;
      if (doPop)  rdPtr <= rdPtr + PTR_ONE;
      case ({doPush, doPop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (doPush && rstN && !flush) mem[wrPtr] <= wrData;
  end

endmodule

// File: rtl/cpu_fifo_periph.sv
// CPU-bus FIFO peripheral: register decode, sticky flags, threshold and read mux.
// Interrupt logic is built only when FIFO_IRQ_EN is defined; otherwise Irq is tied low.
module cpu_fifo_periph
  import cpu_fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             CS,
  input  logic             Rd_Wr,
  input  logic [3:0]       Addr,
  input  logic [WIDTH-1:0] DataIn,
  output logic [WIDTH-1:0] DataOut,
  output logic             Irq
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]       count;
  logic                full;
  logic                empty;
  logic [WIDTH-1:0]    head;
  logic                wrAcc;
  logic                rdAcc;
  logic                dataWr;
  logic                dataRd;
  logic                ctrlWr;
  logic                threshWr;
  logic                flushReq;
  logic                clrReq;
  logic                overflow;
  logic                underflow;
  logic [THRESH_W-1:0] thresh;
  logic                levelGe;
  logic                irqEnBit;
  logic [STAT_W-1:0]   status;
  logic [WIDTH-1:0]    rdMux;

  assign wrAcc    = CS & ~Rd_Wr;
  assign rdAcc    = CS & Rd_Wr;
  assign dataWr   = wrAcc && (Addr == ADDR_DATA);
  assign dataRd   = rdAcc && (Addr == ADDR_DATA);
  assign ctrlWr   = wrAcc && (Addr == ADDR_CTRL);
  assign threshWr = wrAcc && (Addr == ADDR_THRESH);
  assign flushReq = ctrlWr & DataIn[CTRL_FLUSH];
  assign clrReq   = ctrlWr & DataIn[CTRL_CLR_STICKY];
  assign levelGe  = (THRESH_W'(count) >= thresh);

  fifo_core #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) uCore (
    .clk    (Clk),
    .rstN   (Rst_n),
    .push   (dataWr),
    .pop    (dataRd),
    .flush  (flushReq),
    .wrData (DataIn),
    .rdData (head),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  always_comb begin
    status                 = '0;
    status[STAT_EMPTY]     = empty;
    status[STAT_FULL]      = full;
    status[STAT_OVERFLOW]  = overflow;
    status[STAT_UNDERFLOW] = underflow;
    status[STAT_LEVEL]     = levelGe;
  end

  always_comb begin
    rdMux = '0;
    case (Addr)
      ADDR_DATA:   if (!empty) rdMux = head;
      ADDR_STATUS: rdMux[STAT_W-1:0] = status;
      ADDR_COUNT:  rdMux[CW-1:0] = count;
      ADDR_CTRL:   rdMux[CTRL_IRQ_EN] = irqEnBit;
      ADDR_THRESH: rdMux[THRESH_W-1:0] = thresh;
      default:     rdMux = '0;
    endcase
  end

  // A sticky clear in the same write as nothing else wins over nothing; set and
  // clear never coincide because they need different addresses.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
      thresh    <= threshRstVal(DEPTH);
      DataOut   <= '0;
    end else begin
      if (rdAcc)           DataOut   <= rdMux;
      if (dataWr && full)  overflow  <= 1'b1;
      if (dataRd && empty) underflow <= 1'b1;
      if (clrReq) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end
      if (threshWr) thresh <= DataIn[THRESH_W-1:0];
    end
  end

`ifdef FIFO_IRQ_EN
  logic irqEn;

  assign irqEnBit = irqEn;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      irqEn <= 1'b0;
      Irq   <= 1'b0;
    end else begin
      if (ctrlWr) irqEn <= DataIn[CTRL_IRQ_EN];
      Irq <= irqEn & (levelGe | overflow | underflow);
    end
  end
`else
  assign irqEnBit = 1'b0;
  assign Irq      = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_fifo_periph.sv
// Self-checking bench for cpu_fifo_periph: expected read data is queued as each
// access is issued and compared when DataOut becomes valid.
module tb_cpu_fifo_periph;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic       CS = 1'b0;
  logic       Rd_Wr = 1'b0;
  logic [3:0] Addr = 4'h0;
  logic [7:0] DataIn = 8'h00;
  logic [7:0] DataOut;
  logic       Irq;

`ifdef FIFO_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  int assertCount = 0;
  int failCount = 0;
  logic [7:0] expQ[$];
  string      tagQ[$];

  cpu_fifo_periph #(.DEPTH(16), .WIDTH(8)) dut (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .CS      (CS),
    .Rd_Wr   (Rd_Wr),
    .Addr    (Addr),
    .DataIn  (DataIn),
    .DataOut (DataOut),
    .Irq     (Irq)
  );

  always #5 Clk = ~Clk;

  task automatic checkEq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  task automatic busWrite(input logic [3:0] a, input logic [7:0] d);
    @(negedge Clk);
    CS = 1'b1; Rd_Wr = 1'b0; Addr = a; DataIn = d;
    @(posedge Clk); #1;
    CS = 1'b0;
  endtask

  task automatic busRead(input logic [3:0] a, input logic [7:0] exp, input string tag);
    expQ.push_back(exp);
    tagQ.push_back(tag);
    @(negedge Clk);
    CS = 1'b1; Rd_Wr = 1'b1; Addr = a;
    @(posedge Clk); #1;
    CS = 1'b0;
    checkEq(tagQ.pop_front(), DataOut, expQ.pop_front());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      CS = 1'b0;
      @(posedge Clk); #1;
    end
  endtask

  initial begin
    repeat (2) @(posedge Clk);
    #1;
    checkEq("rst_dataout", DataOut, 8'h00);
    checkEq("rst_irq", {7'b0, Irq}, 8'h00);
    @(negedge Clk); Rst_n = 1'b1;

    busRead(4'h1, 8'h01, "rst_status");
    busRead(4'h2, 8'h00, "rst_count");
    busRead(4'h4, 8'h08, "rst_thresh");
    busRead(4'h3, 8'h00, "rst_ctrl");

    // fill and drain
    for (int i = 1; i <= 16; i++) busWrite(4'h0, 8'(i));
    busRead(4'h1, 8'h12, "fill_status");
    busRead(4'h2, 8'h10, "fill_count");
    for (int i = 1; i <= 16; i++) busRead(4'h0, 8'(i), "drain_data");
    busRead(4'h1, 8'h01, "drain_status");

    // overflow and underflow
    for (int i = 0; i < 17; i++) busWrite(4'h0, 8'(8'h21 + i));
    busRead(4'h2, 8'h10, "ovf_count");
    busRead(4'h1, 8'h16, "ovf_status");
    for (int i = 0; i < 16; i++) busRead(4'h0, 8'(8'h21 + i), "ovf_data");
    busRead(4'h0, 8'h00, "udf_data");
    busRead(4'h1, 8'h0D, "udf_status");
    busRead(4'h1, 8'h0D, "sticky_hold");
    busWrite(4'h3, 8'h02);
    busRead(4'h1, 8'h01, "sticky_clear");
    busRead(4'h3, 8'h00, "ctrl_rd_low");

    // wrap-around
    for (int i = 0; i < 10; i++) busWrite(4'h0, 8'(8'h50 + i));
    for (int i = 0; i < 10; i++) busRead(4'h0, 8'(8'h50 + i), "pre_wrap_data");
    for (int i = 0; i < 12; i++) busWrite(4'h0, 8'(8'hA0 + i));
    busRead(4'h2, 8'h0C, "wrap_count");
    busRead(4'h1, 8'h10, "wrap_status");
    for (int i = 0; i < 12; i++) busRead(4'h0, 8'(8'hA0 + i), "wrap_data");

    // flush then reset mid-operation with a colliding write
    for (int i = 0; i < 5; i++) busWrite(4'h0, 8'(8'h70 + i));
    busWrite(4'h3, 8'h01);
    busRead(4'h2, 8'h00, "flush_count");
    busRead(4'h1, 8'h01, "flush_status");
    for (int i = 0; i < 3; i++) busWrite(4'h0, 8'(8'h80 + i));
    busWrite(4'h4, 8'h02);
    busRead(4'h4, 8'h02, "thresh_set");
    @(negedge Clk);
    Rst_n = 1'b0; CS = 1'b1; Rd_Wr = 1'b0; Addr = 4'h0; DataIn = 8'h77;
    @(posedge Clk); #1;
    checkEq("midrst_dataout", DataOut, 8'h00);
    @(negedge Clk);
    Rst_n = 1'b1; CS = 1'b0;
    busRead(4'h1, 8'h01, "midrst_status");
    busRead(4'h2, 8'h00, "midrst_count");
    busRead(4'h4, 8'h08, "midrst_thresh");

    // threshold boundaries
    busWrite(4'h4, 8'h00);
    busRead(4'h1, 8'h11, "thresh0_status");
    busWrite(4'h4, 8'hFF);
    busRead(4'h4, 8'h1F, "thresh_mask");
    for (int i = 0; i < 16; i++) busWrite(4'h0, 8'(i));
    busRead(4'h1, 8'h02, "thresh31_status");
    busWrite(4'h4, 8'h10);
    busRead(4'h1, 8'h12, "thresh16_status");
    busWrite(4'h3, 8'h01);
    busRead(4'h1, 8'h01, "flush_full_status");

    // interrupt
    busWrite(4'h4, 8'h03);
    busWrite(4'h3, 8'h80);
    busRead(4'h3, IRQ_ON ? 8'h80 : 8'h00, "irqen_rd");
    busWrite(4'h0, 8'h61);
    busWrite(4'h0, 8'h62);
    busRead(4'h1, 8'h00, "below_thresh");
    checkEq("irq_below", {7'b0, Irq}, 8'h00);
    busWrite(4'h0, 8'h63);
    busRead(4'h1, 8'h10, "at_thresh");
    checkEq("irq_at", {7'b0, Irq}, {7'b0, IRQ_ON});
    busRead(4'h0, 8'h61, "irq_pop");
    idle(1);
    checkEq("irq_after_pop", {7'b0, Irq}, 8'h00);

    // underflow-driven interrupt, then combined flush + sticky clear
    busWrite(4'h3, 8'h81);
    busRead(4'h0, 8'h00, "udf2_data");
    busRead(4'h1, 8'h09, "udf2_status");
    checkEq("irq_udf", {7'b0, Irq}, {7'b0, IRQ_ON});
    busWrite(4'h0, 8'h91);
    busWrite(4'h3, 8'h03);
    busRead(4'h2, 8'h00, "both_count");
    busRead(4'h1, 8'h01, "both_status");
    busRead(4'h3, 8'h00, "both_ctrl");
    checkEq("irq_off", {7'b0, Irq}, 8'h00);

    // unmapped and deselected access
    busWrite(4'h9, 8'hFF);
    busRead(4'h9, 8'h00, "unmapped_9");
    busRead(4'hF, 8'h00, "unmapped_f");
    busWrite(4'h0, 8'hC1);
    busWrite(4'h0, 8'hC2);
    busRead(4'h2, 8'h02, "pre_cs_count");
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      CS = 1'b0; Rd_Wr = 1'b0; Addr = 4'h0; DataIn = 8'(8'hE0 + i);
      @(posedge Clk); #1;
    end
    @(negedge Clk);
    CS = 1'b0; Rd_Wr = 1'b1; Addr = 4'h0;
    @(posedge Clk); #1;
    checkEq("cs0_dataout_hold", DataOut, 8'h02);
    busRead(4'h2, 8'h02, "cs0_count");
    busRead(4'h0, 8'hC1, "cs0_data0");
    busRead(4'h0, 8'hC2, "cs0_data1");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cpu_fifo_periph.md
CPU_FIFO_PERIPH -- requirements
Module: cpu_fifo_periph

Interface
- REQ-001 SHALL have parameter DEPTH, default 16: FIFO entries (power of two, 2..16).
- REQ-002 SHALL have parameter WIDTH, default 8: data width; equals CPU bus width.
- REQ-003 SHALL have port Clk, input, 1 bit: single clock; all logic rising-edge.
- REQ-004 SHALL have port Rst_n, input, 1 bit: reset, synchronous and active-low.
- REQ-005 SHALL have port CS, input, 1 bit: chip select; an access occurs on each edge with CS=1.
- REQ-006 SHALL have port Rd_Wr, input, 1 bit: 1 = read, 0 = write.
- REQ-007 SHALL have port Addr, input, 4 bits: register address.
- REQ-008 SHALL have port DataIn, input, WIDTH bits: write data.
- REQ-009 SHALL have port DataOut, output, WIDTH bits: registered read data.
- REQ-010 SHALL have port Irq, output, 1 bit: registered level interrupt.

Function
- REQ-011 SHALL register DataOut: read data is valid on the cycle after the read edge and holds until the next read.
- REQ-012 SHALL make no state change on any edge with CS=0.
- REQ-013 SHALL implement this register map:
  - 0x0 DATA:
    - write pushes DataIn when not full;
    - read returns the head and pops when not empty.
  - 0x1 STATUS, RO:
    - bit0 empty, bit1 full, bit2 overflow, bit3 underflow, bit4 level>=THRESH;
    - all other bits 0.
  - 0x2 COUNT, RO: occupancy 0..DEPTH, zero-extended.
  - 0x3 CTRL:
    - write bit0=1 flushes; write bit1=1 clears overflow and underflow;
    - bit7 is IRQ_EN, RW;
    - bits 0 and 1 read as 0.
  - 0x4 THRESH, RW: bits[4:0] hold the threshold, bits[7:5] read 0.
  - 0x5..0xF: read 0x00; writes are ignored.
- REQ-014 SHALL ignore a write to DATA when full and set sticky overflow; contents and count are unchanged.
- REQ-015 SHALL return 0x00 on a DATA read when empty and set sticky underflow; pointers are unchanged.
- REQ-016 SHALL wrap read and write pointers modulo DEPTH; count distinguishes full from empty.
- REQ-017 SHALL, on flush, zero both pointers and count on that edge; memory contents need not be cleared.
- REQ-018 SHALL, on one CTRL write with bit0=1 and bit1=1, perform flush and sticky clear together.
- REQ-019 SHALL NOT auto-clear sticky flags on a STATUS read.
- REQ-020 SHALL reflect a DATA push or pop in STATUS and COUNT reads issued on the following edge.
- REQ-021 SHALL compute level>=THRESH unsigned with 5-bit operands; THRESH=0 makes bit4 always 1.

Reset
- REQ-022 SHALL, on Rst_n=0 at an edge, reset to the following values:
  - pointers and count 0;
  - flags 0, IRQ_EN 0;
  - THRESH = DEPTH/2;
  - DataOut 0x00, Irq 0.
- REQ-023 SHALL let reset override any simultaneous bus access; an access during reset is discarded.
- REQ-024 SHALL discard FIFO contents when reset is asserted mid-operation; empty=1 on the first read after release.

Configuration
- REQ-025 SHALL, with FIFO_IRQ_EN defined, drive Irq registered as IRQ_EN AND (level>=THRESH OR overflow OR underflow).
- REQ-026 SHALL, with FIFO_IRQ_EN undefined:
  - tie Irq to 0;
  - make CTRL bit7 read 0 and ignore writes to it.
- In both cases, REQ-027 SHALL keep all other register behaviour identical.

Structure
- REQ-028 SHALL place the address constants (ADDR_DATA..ADDR_THRESH), STATUS bit indices, CTRL bit indices and the THRESH reset value in shared package cpu_fifo_pkg.
- REQ-029 SHALL instantiate one sub-module, fifo_core:
  - holds storage, pointers, count, full and empty;
  - push/pop strobe interface;
  - the register decode stays in cpu_fifo_periph.

Verification
- REQ-030 SHALL cover fill and drain:
  - stimulus: write 0x01..0x10 to DATA, then read DATA 16 times;
  - required: STATUS=0x12 when full (full, level>=8);
  - required: reads return 0x01..0x10 in order;
  - required: final STATUS=0x01.
- REQ-031 SHALL cover overflow and underflow:
  - stimulus: 17 writes to a full-bound FIFO;
  - required: COUNT=16, STATUS bit2=1, and the 17th value never appears;
  - stimulus: 17 reads;
  - required: 17th read returns 0x00 and STATUS bit3=1;
  - stimulus: CTRL write 0x02;
  - required: STATUS bits 2 and 3 return 0.
- REQ-032 SHALL cover wrap-around:
  - stimulus: push 10, pop 10, then push 0xA0..0xAB (12);
  - required: COUNT=12;
  - required: reads return 0xA0..0xAB.
- REQ-033 SHALL cover flush and reset:
  - stimulus: push 5, then CTRL write 0x01;
  - required: COUNT=0, STATUS=0x01 (THRESH=8);
  - stimulus: push 3, then Rst_n=0 for 1 cycle;
  - required: COUNT=0 and THRESH reads 0x08.
- REQ-034 SHALL cover the interrupt with FIFO_IRQ_EN defined:
  - stimulus: THRESH=3, CTRL=0x80, push 2;
  - required: Irq=0;
  - stimulus: third push;
  - required: Irq=1 on the next edge;
  - stimulus: pop 1;
  - required: Irq=0;
  - without the macro, Irq=0 throughout.
- REQ-035 SHALL cover unmapped and deselected access:
  - stimulus: write 0xFF to 0x9, then read 0x9;
  - required: read returns 0x00;
  - stimulus: CS=0 with DATA write strobes;
  - required: COUNT is unchanged.
